// File: rtl/adc_scan_scheduler.sv
// Round-robin scan scheduler for the shared dual-slope ADC: selects each enabled mux
// channel, waits for settling, starts a conversion and hands the tagged count downstream.
module adc_scan_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 650,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RESULT_W       = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [3:0]          ch_mask_i,
  output logic                adc_start_o,
  input  logic                adc_eoc_i,
  input  logic [RESULT_W-1:0] adc_result_i,
  output logic [1:0]          mux_sel_o,
  output logic                mux_en_o,
  output logic [RESULT_W-1:0] result_data_o,
  output logic [1:0]          result_ch_o,
  output logic                result_err_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                busy_o
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WDOG_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    CH_LIMIT    = 4'((1 << NUM_CH) - 1);
  localparam logic [1:0]    LAST_RST    = 2'(NUM_CH - 1);

  // IDLE wait enable | SELECT pick channel | SETTLE mux settling | CONVERT await eoc | OUTPUT hold result
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONVERT, OUTPUT} state_t;

  state_t                state_q;
  logic [1:0]            last_ch_q;
  logic [1:0]            mux_sel_q;
  logic                  mux_en_q;
  logic                  adc_start_q;
  logic                  busy_q;
  logic [SW-1:0]         settle_cnt_q;
  logic [TW-1:0]         wdog_q;
  logic [RESULT_W-1:0]   result_data_q;
  logic [1:0]            result_ch_q;
  logic                  result_err_q;
  logic                  result_valid_q;

  logic [3:0] mask_eff;
  logic [1:0] next_ch_d;
  logic [1:0] idx;
  logic       found;

  assign mask_eff = ch_mask_i & CH_LIMIT;

  always_comb begin
    next_ch_d = last_ch_q;
    idx       = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = 2'((int'(last_ch_q) + i) % NUM_CH);
      if (!found && mask_eff[idx]) begin
        next_ch_d = idx;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      last_ch_q      <= LAST_RST;
      mux_sel_q      <= '0;
      mux_en_q       <= 1'b0;
      adc_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      settle_cnt_q   <= '0;
      wdog_q         <= '0;
      result_data_q  <= '0;
      result_ch_q    <= '0;
      result_err_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      adc_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && (|mask_eff)) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (|mask_eff) begin
            mux_sel_q    <= next_ch_d;
            last_ch_q    <= next_ch_d;
            settle_cnt_q <= SETTLE_LOAD;
            mux_en_q     <= 1'b1;
            state_q      <= SETTLE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_q     <= CONVERT;
            adc_start_q <= 1'b1;
            wdog_q      <= WDOG_LOAD;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end
        CONVERT: begin
          if (adc_eoc_i) begin
            result_data_q  <= adc_result_i;
            result_ch_q    <= mux_sel_q;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b1;
            mux_en_q       <= 1'b0;
            state_q        <= OUTPUT;
          end else if (wdog_q == '0) begin
            result_data_q  <= '1;
            result_ch_q    <= mux_sel_q;
            result_err_q   <= 1'b1;
            result_valid_q <= 1'b1;
            mux_en_q       <= 1'b0;
            state_q        <= OUTPUT;
          end else if (!adc_start_q) begin
            // the start-pulse cycle itself does not count toward the watchdog
            wdog_q <= wdog_q - 1'b1;
          end
        end
        OUTPUT: begin
          if (result_ready_i) begin
            result_valid_q <= 1'b0;
            if (enable_i) begin
              state_q <= SELECT;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_start_o    = adc_start_q;
  assign mux_sel_o      = mux_sel_q;
  assign mux_en_o       = mux_en_q;
  assign busy_o         = busy_q;
  assign result_data_o  = result_data_q;
  assign result_ch_o    = result_ch_q;
  assign result_err_o   = result_err_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: a short-watchdog instance for scan/timeout
// behaviour and a long-watchdog instance for the slow single-channel conversion.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  ch_mask = 4'b0000;
  logic        adc_eoc = 1'b0;
  logic [19:0] adc_result = '0;
  logic        res_ready = 1'b0;

  logic        adc_start, mux_en, res_err, res_valid, busy;
  logic [1:0]  mux_sel, res_ch;
  logic [19:0] res_data;

  logic        l_start, l_mux_en, l_err, l_valid, l_busy;
  logic [1:0]  l_mux_sel, l_ch;
  logic [19:0] l_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  adc_scan_scheduler #(.NUM_CH(4), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50), .RESULT_W(20)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .ch_mask_i(ch_mask),
    .adc_start_o(adc_start), .adc_eoc_i(adc_eoc), .adc_result_i(adc_result),
    .mux_sel_o(mux_sel), .mux_en_o(mux_en), .result_data_o(res_data),
    .result_ch_o(res_ch), .result_err_o(res_err), .result_valid_o(res_valid),
    .result_ready_i(res_ready), .busy_o(busy)
  );

  adc_scan_scheduler #(.NUM_CH(4), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1000), .RESULT_W(20)) u_long (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .ch_mask_i(ch_mask),
    .adc_start_o(l_start), .adc_eoc_i(adc_eoc), .adc_result_i(adc_result),
    .mux_sel_o(l_mux_sel), .mux_en_o(l_mux_en), .result_data_o(l_data),
    .result_ch_o(l_ch), .result_err_o(l_err), .result_valid_o(l_valid),
    .result_ready_i(res_ready), .busy_o(l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    adc_eoc = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!adc_start && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(adc_start), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, 32'(adc_start), 32'd0);
    chk({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
    chk({tag, "_mux_en"}, 32'(mux_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_data"}, 32'(res_data), 32'd0);
    chk({tag, "_ch"}, 32'(res_ch), 32'd0);
    chk({tag, "_err"}, 32'(res_err), 32'd0);
  endtask

  initial begin
    int exp_ch[5];
    int bad;
    exp_ch = '{0, 1, 3, 0, 1};

    // reset values
    tick();
    tick();
    chk_reset_outs("rst");

    // single channel, slow conversion on the long-watchdog instance
    rst = 1'b0;
    ch_mask = 4'b0001;
    enable = 1'b1;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("single_start_early", 32'(l_start), 32'd0);
    tick();
    chk("single_start_c6", 32'(l_start), 32'd1);
    chk("single_mux_sel", 32'(l_mux_sel), 32'd0);
    chk("single_mux_en", 32'(l_mux_en), 32'd1);
    tick();
    chk("single_start_1cyc", 32'(l_start), 32'd0);
    for (int i = 0; i < 99; i++) tick();
    chk("single_no_valid_yet", 32'(l_valid), 32'd0);
    adc_eoc = 1'b1;
    adc_result = 20'h01234;
    tick();
    adc_eoc = 1'b0;
    chk("single_valid", 32'(l_valid), 32'd1);
    chk("single_data", 32'(l_data), 32'h01234);
    chk("single_ch", 32'(l_ch), 32'd0);
    chk("single_err", 32'(l_err), 32'd0);
    chk("single_busy", 32'(l_busy), 32'd1);

    // round-robin over mask 1011
    do_reset();
    ch_mask = 4'b1011;
    res_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("rr%0d", k));
      chk($sformatf("rr%0d_mux_sel", k), 32'(mux_sel), 32'(exp_ch[k]));
      for (int i = 0; i < 5; i++) tick();
      adc_eoc = 1'b1;
      adc_result = 20'(20'h00100 + k);
      tick();
      adc_eoc = 1'b0;
      chk($sformatf("rr%0d_valid", k), 32'(res_valid), 32'd1);
      chk($sformatf("rr%0d_ch", k), 32'(res_ch), 32'(exp_ch[k]));
      chk($sformatf("rr%0d_data", k), 32'(res_data), 32'h00100 + 32'(k));
    end

    // watchdog timeout, then coincident eoc/timeout on the next channel
    do_reset();
    ch_mask = 4'b0011;
    res_ready = 1'b1;
    enable = 1'b1;
    wait_start("to");
    for (int i = 0; i < 50; i++) tick();
    chk("to_valid_c50", 32'(res_valid), 32'd0);
    tick();
    chk("to_valid_c51", 32'(res_valid), 32'd1);
    chk("to_data", 32'(res_data), 32'hFFFFF);
    chk("to_err", 32'(res_err), 32'd1);
    chk("to_ch", 32'(res_ch), 32'd0);
    wait_start("co");
    chk("co_mux_sel", 32'(mux_sel), 32'd1);
    for (int i = 0; i < 50; i++) tick();
    adc_eoc = 1'b1;
    adc_result = 20'h00042;
    tick();
    adc_eoc = 1'b0;
    chk("co_valid", 32'(res_valid), 32'd1);
    chk("co_data", 32'(res_data), 32'h00042);
    chk("co_err", 32'(res_err), 32'd0);
    chk("co_ch", 32'(res_ch), 32'd1);

    // backpressure with enable dropped mid-CONVERT
    do_reset();
    ch_mask = 4'b0001;
    res_ready = 1'b0;
    enable = 1'b1;
    wait_start("bp");
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    tick();
    tick();
    adc_eoc = 1'b1;
    adc_result = 20'h00777;
    tick();
    adc_eoc = 1'b0;
    chk("bp_valid", 32'(res_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid !== 1'b1 || res_data !== 20'h00777 || res_ch !== 2'd0 ||
          res_err !== 1'b0 || adc_start !== 1'b0 || busy !== 1'b1 || mux_en !== 1'b0) bad++;
      tick();
    end
    chk("bp_stable_bad_cycles", 32'(bad), 32'd0);
    res_ready = 1'b1;
    tick();
    chk("bp_valid_after", 32'(res_valid), 32'd0);
    chk("bp_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_start", 32'(adc_start), 32'd0);

    // asynchronous reset mid-SETTLE, then a stray eoc
    do_reset();
    ch_mask = 4'b0001;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_mux_en", 32'(mux_en), 32'd1);
    chk("rs_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("rs_async");
    #3;
    rst = 1'b0;
    tick();
    adc_eoc = 1'b1;
    adc_result = 20'h0ABCD;
    tick();
    adc_eoc = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rs_late_eoc_valid", 32'(res_valid), 32'd0);
    chk("rs_late_eoc_data", 32'(res_data), 32'd0);
    chk("rs_late_eoc_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
